// File: rtl/mux_rr_scheduler_pkg.sv
// rtl/mux_rr_scheduler_pkg.sv - shared constants and helpers for the 8-way mux scheduler
package mux_rr_scheduler_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [N_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// rtl/mux_rr_scheduler_if.sv - request/grant/select bundle between requesters and scheduler
interface mux_rr_scheduler_if;
    import mux_rr_scheduler_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  sel_valid
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output sel_valid
    );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick8.sv
// rtl/mux_rr_scheduler_rr_pick8.sv - combinational rotating priority pick over 8 requests
module rr_pick8
    import mux_rr_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] win,
    output logic             found
);

    // Walk from start upward; the 3-bit index sum wraps naturally at 8.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[start + SEL_W'(i)]) begin
                found = 1'b1;
                win   = start + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin owner of the 8-to-1 mux select with bounded time slice
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_rr_scheduler_if.slave  bus
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [0:0]       state_q;
    logic [HW-1:0]    hold_q;
    logic [SEL_W-1:0] last_q;
    logic [N_REQ-1:0] grant_q;
    logic [SEL_W-1:0] sel_q;
    logic             sel_valid_q;

    logic [SEL_W-1:0] win;
    logic             found;
    logic             slice_end;

    // Search starts just past the previous owner so it is considered last.
    rr_pick8 u_pick (
        .req   (bus.req),
        .start (last_q + SEL_W'(1)),
        .win   (win),
        .found (found)
    );

    assign slice_end = !bus.req[last_q] || (hold_q == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            last_q      <= SEL_W'(N_REQ - 1);
            grant_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
        end else if (state_q == ST_GRANT && !slice_end) begin
            hold_q <= hold_q + HW'(1);
        end else if (found) begin
            state_q     <= ST_GRANT;
            hold_q      <= '0;
            last_q      <= win;
            grant_q     <= onehot_of(win);
            sel_q       <= win;
            sel_valid_q <= 1'b1;
        end else begin
            // sel keeps its last value while idle
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            grant_q     <= '0;
            sel_valid_q <= 1'b0;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;

endmodule
